// File: rtl/mul_sequencer.sv
// rtl/mul_sequencer.sv - iterative shift-add MUL/MLA controller that borrows the execute-stage ALU
// Define MUL_EARLY_TERM_EN to stop iterating once the remaining multiplier bits are all zero.
`timescale 1ns/1ps
module mul_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             StartE,
  input  logic             FlushE,
  input  logic             AccumulateE,
  input  logic             SetFlagsE,
  input  logic [WIDTH-1:0] RmE,
  input  logic [WIDTH-1:0] RsE,
  input  logic [WIDTH-1:0] RnE,
  input  logic [WIDTH-1:0] ALUResultE,
  output logic             StallE,
  output logic             ALUOverride,
  output logic [2:0]       ALUOperationOv,
  output logic             ALUCarryOv,
  output logic [WIDTH-1:0] SrcAOv,
  output logic [WIDTH-1:0] SrcBOv,
  output logic             MulDone,
  output logic [WIDTH-1:0] MulResult,
  output logic             NZWrite,
  output logic [1:0]       NZFlags
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] acc, mcand, mplier;
  logic [CW-1:0]    count;
  logic             sflag;
  logic             accept, last_iter;

  assign accept = (state == IDLE) & StartE & ~FlushE;

`ifdef MUL_EARLY_TERM_EN
  // Once the shifted-out multiplier is empty the remaining adds would all be +0.
  assign last_iter = (count == LAST) | ((mplier >> 1) == '0);
`else
  assign last_iter = (count == LAST);
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      sflag  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (accept) begin
            mcand  <= RsE;
            mplier <= RmE;
            acc    <= AccumulateE ? RnE : '0;
            count  <= '0;
            sflag  <= SetFlagsE;
          end
        end
        RUN: begin
          acc    <= ALUResultE;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (FlushE) state_next = IDLE;
               else if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Everything is gated by reset so the pipeline sees a quiet sequencer during reset.
  always_comb begin
    StallE         = 1'b0;
    ALUOverride    = 1'b0;
    ALUOperationOv = 3'b000;
    ALUCarryOv     = 1'b0;
    SrcAOv         = '0;
    SrcBOv         = '0;
    MulDone        = 1'b0;
    MulResult      = '0;
    NZWrite        = 1'b0;
    NZFlags        = 2'b00;
    if (reset) begin
      ALUOperationOv = 3'b010;
      StallE         = accept | (state == RUN);
      case (state)
        RUN: begin
          ALUOverride = 1'b1;
          SrcAOv      = acc;
          SrcBOv      = mplier[0] ? mcand : '0;
        end
        DONE: begin
          MulDone   = ~FlushE;
          MulResult = acc;
          NZFlags   = {acc[WIDTH-1], acc == '0};
          NZWrite   = sflag & ~FlushE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Execute-stage multiply controller for the pipelined core. It runs MUL/MLA as an iterative shift-add and borrows the existing execute-stage ALU for one ADD per cycle. While it runs, it stalls the pipeline, overrides the ALU operation and operands, collects the ALU result each cycle, and then presents the product plus N/Z flags to the normal execute result path.

## Interface
- WIDTH, 32, operand/result width; iteration counter is $clog2(WIDTH) bits
- clk  in  1  core clock
- reset  in  1  synchronous, active-low reset
- StartE  in  1  multiply instruction present in execute stage
- FlushE  in  1  execute-stage flush (branch/exception)
- AccumulateE  in  1  MLA (add RnE to product)
- SetFlagsE  in  1  S bit; update N/Z on completion
- RmE  in  WIDTH  multiplier
- RsE  in  WIDTH  multiplicand
- RnE  in  WIDTH  accumulate operand
- ALUResultE  in  WIDTH  sum returned by the shared ALU
- StallE  out  1  hold fetch/decode/execute registers
- ALUOverride  out  1  ALU operand/operation mux select, 1 = sequencer owns ALU
- ALUOperationOv  out  3  forced ALU operation, always 3'b010 (SUM)
- ALUCarryOv  out  1  forced carry-in, always 0
- SrcAOv, SrcBOv  out  WIDTH  forced ALU operands
- MulDone  out  1  product valid this cycle
- MulResult  out  WIDTH  product (low WIDTH bits)
- NZWrite  out  1  write N and Z flags this cycle
- NZFlags  out  2  {N, Z} of MulResult

## Operation
- States: IDLE, RUN, DONE. Reset puts the block in IDLE and clears the acc, mcand, mplier and count registers.
- **IDLE**
  - If StartE & ~FlushE: latch mcand=RsE, mplier=RmE, acc = AccumulateE ? RnE : 0, count=0, sflag=SetFlagsE; go to RUN.
  - FlushE has priority over StartE.
- **RUN**
  - ALUOverride=1, SrcAOv=acc, SrcBOv = mplier[0] ? mcand : 0.
  - Next cycle: acc<=ALUResultE, mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
  - Go to DONE when count==WIDTH-1, or when early termination fires (see Configuration).
  - FlushE in RUN goes to IDLE; the product is discarded.
- **DONE**
  - MulDone=1, MulResult=acc, NZFlags={acc[WIDTH-1], acc==0}, NZWrite=sflag.
  - C and V are never written.
  - Unconditionally go to IDLE.
  - FlushE in DONE suppresses MulDone and NZWrite.
- StallE = (IDLE & StartE & ~FlushE) | RUN. StallE is combinational.
- Arithmetic wraps modulo 2^WIDTH; carry-out of the ALU is ignored.
- ALUOverride, MulDone and NZWrite are 0 outside the states listed above. All outputs are 0 while reset is asserted.

## Timing
- StartE accepted in cycle T (IDLE). RUN occupies T+1 … T+N. DONE is T+N+1.
- N=WIDTH without early termination.
- With early termination: N = max(1, msb(RmE)+1), where msb(0) is treated as 0.
- StallE is high in T … T+N and low in DONE, so the multiply leaves execute on the DONE edge.
- A back-to-back multiply is accepted in the IDLE cycle after DONE: one idle cycle minimum between completions.
- Reset mid-operation: next cycle is IDLE, with StallE=0 and no MulDone.
- ALUResultE must be combinational from SrcAOv/SrcBOv within the same cycle; no ALU pipelining.

## Configuration
- MUL_EARLY_TERM_EN
  - Defined: leave RUN after the cycle in which (mplier>>1)==0, so the iteration count follows multiplier magnitude.
  - Undefined: always exactly WIDTH RUN cycles, giving a deterministic latency of WIDTH+1 stall cycles.
- Results and flags are identical in both builds.

## Test plan
- MUL, RmE=6, RsE=7, SetFlagsE=1, macro off:
  - StallE high 33 cycles.
  - MulDone at T+33 with MulResult=42, NZWrite=1, NZFlags=2'b00.
- Same stimulus, macro on:
  - RUN lasts 3 cycles; MulDone at T+4, MulResult=42.
- MLA, RmE=2, RsE=0xFFFFFFFF, RnE=5:
  - MulResult=0x00000003, N=0, Z=0.
  - With macro on, RUN lasts 2 cycles.
- RmE=0, RsE=0x1234, SetFlagsE=1, macro on:
  - 1 RUN cycle; MulResult=0, NZFlags=2'b01.
- RmE=0x80000000, RsE=1:
  - MulResult=0x80000000, NZFlags=2'b10, 32 RUN cycles in both builds.
- Abort cases (macro off):
  - FlushE on the 5th RUN cycle: next cycle IDLE, StallE=0, no MulDone.
  - StartE with FlushE in IDLE: no stall.
  - reset low mid-RUN: all outputs 0 next cycle.
